// File: rtl/dram_arb_pkg.sv
// Shared types and default sizing for the data-RAM arbiter and its round-robin picker.
package dram_arb_pkg;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 2;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_DEPTH_W  = 4;
    localparam int DEF_LOCK_TMO = 16;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] gnt_dbl;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_grant;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        rot_req   = req_dbl[NUM_REQ-1:0];
        rot_grant = rot_req & (~rot_req + NUM_REQ'(1));
        gnt_dbl   = {rot_grant, rot_grant} << ptr;
        grant     = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter with lockable ownership in front of the single-port data RAM.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH_W  = DEF_DEPTH_W,
    parameter int LOCK_TMO = DEF_LOCK_TMO
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_ena,
    output logic                      mem_rea,
    output logic                      mem_wea,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_dia,
    input  logic [DATA_W-1:0]         mem_doa
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TMO + 1);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(1) << DEPTH_W;

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]   lock_owner_reg, lock_owner_next;
    logic [CNT_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [NUM_REQ-1:0] pend_valid_reg, pend_valid_next;
    logic [NUM_REQ-1:0] pend_err_reg, pend_err_next;
    logic               pend_read_reg, pend_read_next;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_hot;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               in_range;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   ptr_after;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;
    logic               sel_lock;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign owner_hot[gi] = (lock_owner_reg == PTR_W'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant)
    );

    // While locked, only the owner can see ready, and only when it is asking.
    always_comb begin
        grant = '0;
        if (!reset) begin
            case (state_reg)
                ARB:     grant = rr_grant;
                LOCKED:  grant = req_valid & owner_hot;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx   = PTR_W'(i);
                sel_addr  = addr_arr[i];
                sel_wdata = wdata_arr[i];
                sel_we    = req_we[i];
                sel_lock  = req_lock[i];
            end
        end
    end

    assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;
    assign ptr_after = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);

    assign mem_ena  = accept & in_range;
    assign mem_wea  = mem_ena & sel_we;
    assign mem_rea  = mem_ena & ~sel_we;
    assign mem_addr = sel_addr;
    assign mem_dia  = sel_wdata;

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_owner_next = lock_owner_reg;
        lock_cnt_next   = lock_cnt_reg;
        pend_valid_next = grant;
        pend_err_next   = grant & {NUM_REQ{~in_range}};
        pend_read_next  = mem_rea;

        if (accept) begin
            rr_ptr_next = ptr_after;
        end

        case (state_reg)
            ARB: begin
                if (accept && sel_lock) begin
                    state_next      = LOCKED;
                    lock_owner_next = sel_idx;
                    lock_cnt_next   = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    lock_cnt_next = '0;
                    if (!sel_lock) begin
                        state_next = ARB;
                    end
                end else if (|(req_valid & owner_hot)) begin
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == CNT_W'(LOCK_TMO - 1)) begin
                    // Owner went quiet for too long; release to round-robin.
                    state_next    = ARB;
                    lock_cnt_next = '0;
                end else begin
                    lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB;
            rr_ptr_reg     <= '0;
            lock_owner_reg <= '0;
            lock_cnt_reg   <= '0;
            pend_valid_reg <= '0;
            pend_err_reg   <= '0;
            pend_read_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_err_reg   <= pend_err_next;
            pend_read_reg  <= pend_read_next;
        end
    end

    // Responses are masked while reset is high so an in-flight read is dropped.
    assign rsp_valid = reset ? '0 : pend_valid_reg;
    assign rsp_err   = reset ? '0 : pend_err_reg;
    assign rsp_rdata = (pend_read_reg && !reset) ? mem_doa : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Random and directed stimulus for dram_arbiter, scored against a cycle-level reference model.
module tb_dram_arbiter;

    localparam int N     = 2;
    localparam int AW    = 11;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    valid_v = '0;
    logic [N-1:0]    we_v = '0;
    logic [N-1:0]    lock_v = '0;
    logic [AW-1:0]   addr_v  [N];
    logic [DW-1:0]   wdata_v [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata, mem_dia;
    logic [DW-1:0] mem_doa;
    logic [AW-1:0] mem_addr;
    logic          mem_ena, mem_rea, mem_wea;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = addr_v[i];
            req_wdata[i*DW +: DW] = wdata_v[i];
        end
    end

    dram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (valid_v),
        .req_we    (we_v),
        .req_lock  (lock_v),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_ena   (mem_ena),
        .mem_rea   (mem_rea),
        .mem_wea   (mem_wea),
        .mem_addr  (mem_addr),
        .mem_dia   (mem_dia),
        .mem_doa   (mem_doa)
    );

    function automatic logic [63:0] init_word(int i);
        return 64'h1111_2222_0000_0000 ^ {32'(i) * 32'h9E37_79B9, 32'(i)};
    endfunction

    // Behavioural single-port RAM with registered read.
    logic [DW-1:0] ram [DEPTH];
    logic init_ram = 1'b1;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            mem_doa <= '0;
        end else if (mem_ena) begin
            if (mem_wea) ram[mem_addr[3:0]] <= mem_dia;
            if (mem_rea) mem_doa <= ram[mem_addr[3:0]];
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit            m_locked = 0;
    int            m_owner = 0;
    int            m_ptr = 0;
    int            m_idle = 0;
    logic [63:0]   m_mem [DEPTH];
    logic [N-1:0]  e_rsp_v = '0;
    logic [N-1:0]  e_rsp_e = '0;
    logic [63:0]   e_rdata = '0;

    function automatic int onehot_idx(logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < N; i++) if (v[i]) begin idx = i; cnt++; end
        return (cnt > 1) ? -2 : idx;
    endfunction

    task automatic run_cycle(output int g_obs, output int g_exp);
        int g;
        bit inr;
        bit is_wr;
        logic [N-1:0] exp_ready;
        logic [N-1:0] nv, ne;
        logic [63:0] nd;
        int a;
        @(negedge clk);
        g = -1;
        if (!reset) begin
            if (m_locked) begin
                if (valid_v[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j = (m_ptr + k) % N;
                    if (g < 0 && valid_v[j]) g = j;
                end
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, reset ? '0 : e_rsp_v);
        check_eq("rsp_err", rsp_err, reset ? '0 : e_rsp_e);
        if (!reset && e_rsp_v != 0) check_eq("rsp_rdata", rsp_rdata, e_rdata);

        nv = '0; ne = '0; nd = '0;
        if (g >= 0) begin
            a     = int'(addr_v[g]);
            inr   = (a < DEPTH);
            is_wr = we_v[g];
            check_eq("mem_ena", mem_ena, inr);
            check_eq("mem_wea", mem_wea, inr && is_wr);
            check_eq("mem_rea", mem_rea, inr && !is_wr);
            if (inr) check_eq("mem_addr", mem_addr, addr_v[g]);
            if (inr && is_wr) check_eq("mem_dia", mem_dia, wdata_v[g]);
            $display("txn t=%0t req=%0d %s addr=%h lock=%0b", $time, g, is_wr ? "WR" : "RD",
                     addr_v[g], lock_v[g]);
            nv = exp_ready;
            ne = inr ? '0 : exp_ready;
            if (inr && !is_wr) nd = m_mem[a];
            if (inr && is_wr) m_mem[a] = wdata_v[g];
        end else begin
            check_eq("mem_en_idle", {mem_ena, mem_wea, mem_rea}, 3'b000);
        end

        if (reset) begin
            m_locked = 0; m_ptr = 0; m_idle = 0;
        end else if (g >= 0) begin
            m_ptr  = (g + 1) % N;
            m_idle = 0;
            if (m_locked) begin
                if (!lock_v[g]) m_locked = 0;
            end else if (lock_v[g]) begin
                m_locked = 1; m_owner = g;
            end
        end else if (m_locked) begin
            m_idle++;
            if (m_idle == TMO) begin m_locked = 0; m_idle = 0; end
        end

        g_obs = onehot_idx(req_ready);
        g_exp = g;
        @(posedge clk);
        #1;
        e_rsp_v = nv; e_rsp_e = ne; e_rdata = nd;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid_v[i] = v; we_v[i] = we; lock_v[i] = lk; addr_v[i] = a; wdata_v[i] = d;
    endtask

    task automatic rand_req(input int i, input int dens);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
        set_req(i, $urandom_range(0, 99) < dens, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0, a, {$urandom, $urandom});
    endtask

    initial begin
        int go, ge, cnt;
        bit seen;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(i);
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
        @(posedge clk); #1;
        init_ram = 1'b0;
        run_cycle(go, ge);
        reset = 1'b0;

        // Both requesters read continuously: grants alternate starting at 0.
        set_req(0, 1, 0, 0, 11'd3, '0);
        set_req(1, 1, 0, 0, 11'd5, '0);
        for (int c = 0; c < 6; c++) begin
            run_cycle(go, ge);
            check_eq("alt_grant", 64'(go), 64'(c % 2));
        end
        set_req(1, 0, 0, 0, '0, '0);

        // Write then read of the same address.
        set_req(0, 1, 1, 0, 11'd7, 64'hDEADBEEF_00000001);
        run_cycle(go, ge);
        set_req(0, 1, 0, 0, 11'd7, '0);
        run_cycle(go, ge);
        set_req(0, 0, 0, 0, '0, '0);
        @(negedge clk);
        check_eq("wr_rd_data", rsp_rdata, 64'hDEADBEEF_00000001);
        @(posedge clk); #1;
        e_rsp_v = '0;

        // Out-of-range read.
        set_req(1, 1, 0, 0, 11'h010, '0);
        run_cycle(go, ge);
        set_req(1, 0, 0, 0, '0, '0);
        run_cycle(go, ge);

        // Lock held by req0 until an unlocking write; req1 follows immediately.
        set_req(0, 1, 0, 1, 11'd2, '0);
        set_req(1, 1, 0, 0, 11'd9, '0);
        run_cycle(go, ge);
        check_eq("lock_take", 64'(go), 64'd0);
        set_req(0, 0, 0, 0, '0, '0);
        for (int c = 0; c < 3; c++) run_cycle(go, ge);
        set_req(0, 1, 1, 0, 11'd2, 64'h0123_4567_89AB_CDEF);
        run_cycle(go, ge);
        check_eq("unlock_wr", 64'(go), 64'd0);
        set_req(0, 0, 0, 0, '0, '0);
        run_cycle(go, ge);
        check_eq("unlock_next", 64'(go), 64'd1);
        set_req(1, 0, 0, 0, '0, '0);

        // Lock timeout: req1 is granted after TMO idle cycles of the owner.
        set_req(0, 1, 0, 1, 11'd4, '0);
        set_req(1, 1, 0, 0, 11'd6, '0);
        run_cycle(go, ge);
        set_req(0, 0, 0, 0, '0, '0);
        cnt = 0; seen = 0;
        while (!seen && cnt < 40) begin
            run_cycle(go, ge);
            cnt++;
            if (go == 1) seen = 1;
        end
        check_eq("tmo_gap", 64'(cnt), 64'(TMO + 1));
        set_req(1, 0, 0, 0, '0, '0);
        run_cycle(go, ge);

        // Reset right after a read is accepted: its response is dropped.
        set_req(1, 1, 0, 0, 11'd8, '0);
        run_cycle(go, ge);
        set_req(1, 0, 0, 0, '0, '0);
        reset = 1'b1;
        run_cycle(go, ge);
        reset = 1'b0;
        set_req(0, 1, 0, 0, 11'd1, '0);
        set_req(1, 1, 0, 0, 11'd1, '0);
        run_cycle(go, ge);
        check_eq("post_rst", 64'(go), 64'd0);

        // Randomized traffic at several densities, with occasional resets.
        for (int ph = 0; ph < 3; ph++) begin
            int dens = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
            for (int c = 0; c < 400; c++) begin
                run_cycle(go, ge);
                for (int i = 0; i < N; i++)
                    if (!valid_v[i] || ge == i) rand_req(i, dens);
                reset = ($urandom_range(0, 149) == 0);
            end
            reset = 1'b0;
        end
        run_cycle(go, ge);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port 64-bit data RAM between NUM_REQ requesters (e.g. the control sequencer and the host loader) using round-robin arbitration with a per-requester lock for atomic read-modify-write.
- Drives the RAM's enable, read-enable, write-enable, address and write-data pins, and returns each requester's read data or write acknowledge one cycle after acceptance.
- Rejects addresses beyond the populated depth with an error response and never touches the RAM for them.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 11, request/RAM address width.
- DATA_W, 64, data width.
- DEPTH_W, 4, log2 of populated RAM entries; valid addresses are 0..2**DEPTH_W-1.
- LOCK_TMO, 16, idle cycles after which a lock owner with req_valid low loses the lock.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep ownership after this request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-cycle response pulse to requester i.
- rsp_err  out  NUM_REQ  qualifies rsp_valid; set for out-of-range addresses.
- rsp_rdata  out  DATA_W  read data, shared by all requesters; valid while any rsp_valid bit is high.
- mem_ena  out  1  to RAM ena.
- mem_rea  out  1  to RAM rea.
- mem_wea  out  1  to RAM wea.
- mem_addr  out  ADDR_W  to RAM addra.
- mem_dia  out  DATA_W  to RAM dia.
- mem_doa  in  DATA_W  from RAM doa; registered, valid the cycle after ena&rea.

Behaviour:
- Reset (sync): state=ARB, rr_ptr=0, lock_cnt=0, all rsp_valid/rsp_err=0, rsp_rdata=0, pending response cleared. While reset is high, req_ready=0 and mem_ena/mem_rea/mem_wea=0.
- Reset mid-operation: a read accepted in the cycle reset rises produces no response. Requesters must reissue.
- FSM states:
  - ARB: grant the first requester with req_valid high, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ. Grant is combinational, so req_ready is at most one-hot and zero when no requester is valid.
  - LOCKED: only lock_owner may be granted; req_ready of every other requester is 0.
- Transitions:
  - On acceptance in ARB: rr_ptr <= (winner+1) mod NUM_REQ. If req_lock is set, go to LOCKED with lock_owner=winner.
  - LOCKED -> ARB when the owner has a request accepted with req_lock=0. That request is serviced; rr_ptr <= owner+1.
  - LOCKED -> ARB when the owner's req_valid has been low for LOCK_TMO consecutive cycles. lock_cnt counts those cycles and resets on any owner req_valid.
- Memory drive (combinational from the accepted request, same cycle):
  - mem_addr = req_addr[i]; mem_dia = req_wdata[i].
  - In range (addr < 2**DEPTH_W): mem_ena=1, mem_wea=req_we, mem_rea=~req_we.
  - Out of range: all three enables 0.
  - No acceptance: enables 0; mem_addr/mem_dia are don't-care.
- Response, latency exactly 1 cycle after acceptance:
  - rsp_valid[i]=1 for one cycle.
  - Read in range: rsp_rdata = mem_doa.
  - Write in range: rsp_rdata = 0.
  - Out of range: rsp_err[i]=1, rsp_rdata=0.
- Throughput: one access per cycle, back-to-back; responses pipeline behind acceptances with no bubbles.
- Same requester, back-to-back write then read of the same address: the read returns the new data (RAM write lands before the next cycle's read).
- Inputs held stable while req_valid & ~req_ready; the block does not check this.

Decomposition:
- Shared package dram_arb_pkg:
  - state enum {ARB, LOCKED};
  - default widths: DATA_W=64, ADDR_W=11, DEPTH_W=4;
  - LOCK_TMO default.
- One sub-module, rr_pick: combinational round-robin priority picker with inputs req[NUM_REQ] and ptr, and output grant one-hot. It is reused by other shared-resource arbiters.

Test Plan:
- Requesters 0 and 1 both read continuously (addr 3, addr 5) -> grants alternate 0,1,0,1. Each rsp_valid arrives 1 cycle after its grant with the RAM contents of addr 3 / addr 5; mem_ena high every cycle.
- Req0 writes 0xDEADBEEF_00000001 to addr 7, then reads addr 7 in the next cycle -> write ack (rsp_err=0) followed by read rsp_rdata=0xDEADBEEF_00000001.
- Req1 reads addr 0x010 (out of range) -> mem_ena stays 0; next cycle rsp_valid[1]=1, rsp_err[1]=1, rsp_rdata=0.
- Req0 reads addr 2 with lock=1 while req1 is valid -> req1 gets no grant until req0 writes addr 2 with lock=0. Req1 is granted the cycle after that write.
- Req0 takes the lock, then drops valid; req1 waits -> req1 is granted exactly after 16 idle cycles (LOCK_TMO).
- Reset asserted in the cycle a read is accepted -> no rsp_valid afterwards; after release, the first grant goes to requester 0 (rr_ptr=0).
